// File: rtl/teclado_emulador.sv
// teclado_emulador: emulates a pressed key on a scanned 4x4 matrix, with timed bounce and hold phases.
// The column follows the row scan combinationally while the internal contact is closed.
module teclado_emulador #(
    parameter int BOUNCE_LEN = 3,
    parameter int SYNC_ROW   = 1,
    parameter int HOLD_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        lin_matriz,
    output logic [3:0]        col_matriz,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        cmd_bounce,
    input  logic              cmd_abort,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done
);
    localparam int SW = BOUNCE_LEN > 1 ? $clog2(BOUNCE_LEN) : 1;
    localparam logic [SW-1:0] SEG_LAST = SW'(BOUNCE_LEN - 1);
    typedef enum logic [2:0] {IDLE, WAIT_ROW, BOUNCE_IN, HOLD, BOUNCE_OUT} state_t;
    state_t            state;
    logic              contact;
    logic [3:0]        key_r, bounce_r, pairs, nb;
    logic [HOLD_W-1:0] hold_r, hold_cnt, hl, hold_ld;
    logic [SW-1:0]     seg;
    logic              seg_end, go;

    assign cmd_ready  = state == IDLE;
    assign busy       = ~cmd_ready;
    assign col_matriz = contact && !lin_matriz[key_r[3:2]] ? ~(4'b0001 << key_r[1:0]) : 4'b1111;
    // In IDLE the command is not latched yet, so closing straight away reads the inputs
    assign nb         = cmd_ready ? cmd_bounce : bounce_r;
    assign hl         = cmd_ready ? cmd_hold : hold_r;
    assign hold_ld    = hl == '0 ? '0 : hl - 1'b1;
    assign seg_end    = seg == SEG_LAST;
    assign go         = cmd_ready ? cmd_valid && SYNC_ROW == 0 : state == WAIT_ROW && !lin_matriz[key_r[3:2]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            contact  <= 1'b0;
            done     <= 1'b0;
            key_r    <= '0;
            hold_r   <= '0;
            bounce_r <= '0;
            pairs    <= '0;
            hold_cnt <= '0;
            seg      <= '0;
        end else begin
            done <= 1'b0;
            if (cmd_ready && cmd_valid) begin
                key_r    <= cmd_key;
                hold_r   <= cmd_hold;
                bounce_r <= cmd_bounce;
            end
            if (!cmd_ready && cmd_abort) begin
                state   <= IDLE;
                contact <= 1'b0;
            end else if (go) begin
                state    <= nb == 4'd0 ? HOLD : BOUNCE_IN;
                contact  <= 1'b1;
                seg      <= '0;
                pairs    <= nb;
                hold_cnt <= hold_ld;
            end else begin
                case (state)
                    IDLE: if (cmd_valid) state <= WAIT_ROW;
                    BOUNCE_IN: begin
                        seg      <= seg_end ? '0 : seg + 1'b1;
                        hold_cnt <= hold_ld;
                        if (seg_end) begin
                            contact <= ~contact;
                            if (!contact) begin
                                pairs <= pairs - 1'b1;
                                if (pairs == 4'd1) state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                        else begin
                            contact <= 1'b0;
                            seg     <= '0;
                            pairs   <= bounce_r;
                            state   <= bounce_r == 4'd0 ? IDLE : BOUNCE_OUT;
                            done    <= bounce_r == 4'd0;
                        end
                    end
                    BOUNCE_OUT: begin
                        seg <= seg_end ? '0 : seg + 1'b1;
                        if (seg_end) begin
                            contact <= ~contact;
                            if (contact) begin
                                pairs <= pairs - 1'b1;
                                if (pairs == 4'd1) begin
                                    state <= IDLE;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_teclado_emulador.sv
// tb_teclado_emulador: scenario tasks with a per-cycle scoreboard of {col_matriz, cmd_ready, busy, done}.
module tb_teclado_emulador;
    typedef logic [6:0] exp_t;
    logic        clk = 1'b0, rst = 1'b0;
    logic [3:0]  lin_matriz = 4'b1111, cmd_key = 4'd0, cmd_bounce = 4'd0, col_matriz;
    logic [15:0] cmd_hold = 16'd0;
    logic        cmd_valid = 1'b0, cmd_abort = 1'b0, cmd_ready, busy, done;
    int          n_chk = 0, n_fail = 0;
    exp_t        q[$];
    exp_t        e;

    always #5 clk = ~clk;

    teclado_emulador #(.BOUNCE_LEN(3), .SYNC_ROW(1), .HOLD_W(16)) dut (
        .clk(clk), .rst(rst), .lin_matriz(lin_matriz), .col_matriz(col_matriz),
        .cmd_valid(cmd_valid), .cmd_key(cmd_key), .cmd_hold(cmd_hold), .cmd_bounce(cmd_bounce),
        .cmd_abort(cmd_abort), .cmd_ready(cmd_ready), .busy(busy), .done(done)
    );

    task automatic test_reset();
        #2;
        q.push_back(7'b1111_1_0_0);
        e = q.pop_front();
        n_chk++;
        if ({col_matriz, cmd_ready, busy, done} !== e) begin
            n_fail++;
            $display("FAIL reset_async: got %b_%b_%b_%b want %b_%b_%b_%b", col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
        end
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        q.push_back(7'b1111_1_0_0);
        e = q.pop_front();
        n_chk++;
        if ({col_matriz, cmd_ready, busy, done} !== e) begin
            n_fail++;
            $display("FAIL reset_held: got %b_%b_%b_%b want %b_%b_%b_%b", col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_scan();
        logic r;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            lin_matriz = ~(4'b0001 << ((c / 4) % 4));
            cmd_valid = c == 0; cmd_key = 4'd5; cmd_hold = 16'd10; cmd_bounce = 4'd0; cmd_abort = 1'b0;
            r = c == 0 || c >= 15;
            q.push_back({(c >= 5 && c <= 14 && lin_matriz == 4'b1101) ? 4'b1101 : 4'b1111, r, !r, c == 15});
            #1;
            e = q.pop_front();
            n_chk++;
            if ({col_matriz, cmd_ready, busy, done} !== e) begin
                n_fail++;
                $display("FAIL scan c%0d: got %b_%b_%b_%b want %b_%b_%b_%b", c, col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_bounce();
        int   lens[9] = '{3, 3, 3, 3, 6, 3, 3, 3, 3};
        logic pat[$];
        logic r;
        pat.push_back(1'b0);
        pat.push_back(1'b0);
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < lens[i]; j++) pat.push_back(i % 2 == 0);
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            lin_matriz = 4'b0000;
            cmd_valid = c == 0; cmd_key = 4'd0; cmd_hold = 16'd6; cmd_bounce = 4'd2; cmd_abort = 1'b0;
            r = c == 0 || c >= 32;
            q.push_back({(c < pat.size() && pat[c]) ? 4'b1110 : 4'b1111, r, !r, c == 32});
            #1;
            e = q.pop_front();
            n_chk++;
            if ({col_matriz, cmd_ready, busy, done} !== e) begin
                n_fail++;
                $display("FAIL bounce c%0d: got %b_%b_%b_%b want %b_%b_%b_%b", c, col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t tbl[12] = '{7'b1111_1_0_0, 7'b1111_0_1_0, 7'b1110_0_1_0, 7'b1110_0_1_0,
                          7'b1110_0_1_0, 7'b1110_0_1_0, 7'b1111_1_0_1, 7'b1111_0_1_0,
                          7'b0111_0_1_0, 7'b0111_0_1_0, 7'b1111_1_0_1, 7'b1111_1_0_0};
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            lin_matriz = 4'b0000; cmd_abort = 1'b0; cmd_bounce = 4'd0;
            cmd_valid = c <= 6;
            cmd_key = c == 0 ? 4'd0 : 4'd7;
            cmd_hold = c == 0 ? 16'd4 : 16'd2;
            q.push_back(tbl[c]);
            #1;
            e = q.pop_front();
            n_chk++;
            if ({col_matriz, cmd_ready, busy, done} !== e) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got %b_%b_%b_%b want %b_%b_%b_%b", c, col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_abort();
        logic r;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            lin_matriz = 4'b0000;
            cmd_valid = c == 0; cmd_key = 4'd10; cmd_hold = 16'd20; cmd_bounce = 4'd1; cmd_abort = c == 10;
            r = c == 0 || c >= 11;
            q.push_back({((c >= 2 && c <= 4) || (c >= 8 && c <= 10)) ? 4'b1011 : 4'b1111, r, !r, 1'b0});
            #1;
            e = q.pop_front();
            n_chk++;
            if ({col_matriz, cmd_ready, busy, done} !== e) begin
                n_fail++;
                $display("FAIL abort c%0d: got %b_%b_%b_%b want %b_%b_%b_%b", c, col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_hold0();
        logic r;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            lin_matriz = 4'b0000;
            cmd_valid = c == 0; cmd_key = 4'd15; cmd_hold = 16'd0; cmd_bounce = 4'd0; cmd_abort = c == 0;
            r = c == 0 || c >= 3;
            q.push_back({c == 2 ? 4'b0111 : 4'b1111, r, !r, c == 3});
            #1;
            e = q.pop_front();
            n_chk++;
            if ({col_matriz, cmd_ready, busy, done} !== e) begin
                n_fail++;
                $display("FAIL hold0 c%0d: got %b_%b_%b_%b want %b_%b_%b_%b", c, col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic r;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            lin_matriz = 4'b0000;
            cmd_valid = c == 0; cmd_key = 4'd0; cmd_hold = 16'd5; cmd_bounce = 4'd3; cmd_abort = 1'b0;
            r = c == 0;
            q.push_back({c >= 2 ? 4'b1110 : 4'b1111, r, !r, 1'b0});
            #1;
            e = q.pop_front();
            n_chk++;
            if ({col_matriz, cmd_ready, busy, done} !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre c%0d: got %b_%b_%b_%b want %b_%b_%b_%b", c, col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
            end
        end
        rst = 1'b0;
        q.push_back(7'b1111_1_0_0);
        #1;
        e = q.pop_front();
        n_chk++;
        if ({col_matriz, cmd_ready, busy, done} !== e) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b_%b_%b_%b want %b_%b_%b_%b", col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            q.push_back(7'b1111_1_0_0);
            #1;
            e = q.pop_front();
            n_chk++;
            if ({col_matriz, cmd_ready, busy, done} !== e) begin
                n_fail++;
                $display("FAIL reset_mid_after c%0d: got %b_%b_%b_%b want %b_%b_%b_%b", c, col_matriz, cmd_ready, busy, done, e[6:3], e[2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_bounce();
        test_back_to_back();
        test_abort();
        test_hold0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/teclado_emulador.md
TECLADO_EMULADOR -- requirements
Module: teclado_emulador

Interface
REQ-001 SHALL have parameter BOUNCE_LEN, default 3, cycles per bounce segment (min 1).
REQ-002 SHALL have parameter SYNC_ROW, default 1, 1 = contact closes only after the key's row is seen scanned.
REQ-003 SHALL have parameter HOLD_W, default 16, width of cmd_hold.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port lin_matriz  input  4  row scan from decoder, active-low (0 = row driven).
REQ-007 SHALL have port col_matriz  output  4  column lines to decoder, active-low, idle 4'b1111.
REQ-008 SHALL have port cmd_valid  input  1  press request.
REQ-009 SHALL have port cmd_key  input  4  key index, row = cmd_key[3:2], col = cmd_key[1:0].
REQ-010 SHALL have port cmd_hold  input  HOLD_W  stable-closed duration in cycles.
REQ-011 SHALL have port cmd_bounce  input  4  bounce pair count N, applied on press and release.
REQ-012 SHALL have port cmd_abort  input  1  cancel the press in progress.
REQ-013 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-014 SHALL have port busy  output  1  equals ~cmd_ready.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL hold internal registered flag contact; col_matriz[c] = 0 iff contact && lin_matriz[row]==0 && c==col, else 1 (combinational from contact and lin_matriz, zero latency).
REQ-017 SHALL treat lin_matriz with several zero bits physically: the column is pulled low if the key's row bit is among them.
REQ-018 SHALL accept a command on a rising edge with cmd_valid && cmd_ready, latching cmd_key, cmd_hold and cmd_bounce; cmd_valid while busy SHALL be ignored.
REQ-019 SHALL implement FSM IDLE -> WAIT_ROW (SYNC_ROW=1) or BOUNCE_IN (SYNC_ROW=0) -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> IDLE.
REQ-020 SHALL leave WAIT_ROW on the edge where lin_matriz[row]==0; contact is 1 from the next cycle.
REQ-021 SHALL in BOUNCE_IN produce N pairs (contact 1 for BOUNCE_LEN, 0 for BOUNCE_LEN); N=0 skips directly to HOLD.
REQ-022 SHALL in HOLD keep contact 1 for exactly cmd_hold cycles; cmd_hold=0 SHALL be treated as 1.
REQ-023 SHALL in BOUNCE_OUT produce N pairs (contact 0 for BOUNCE_LEN, 1 for BOUNCE_LEN), then open contact; N=0 opens immediately after HOLD.
REQ-024 SHALL pulse done for one cycle in the first IDLE cycle after completion, with cmd_ready=1 in that cycle; a new command is accepted on that edge.
REQ-025 SHALL on cmd_abort in any non-IDLE state clear contact and return to IDLE on the next edge, with no done pulse; abort has priority over all transitions and is ignored in IDLE.
REQ-026 SHALL use segment and hold counters wide enough for BOUNCE_LEN and HOLD_W with no wrap before terminal count.

Reset
REQ-027 SHALL on rst=0 immediately (asynchronously) force state IDLE, contact 0, col_matriz 4'b1111, cmd_ready 1, busy 0, done 0, counters 0.
REQ-028 SHALL on rst asserted mid-operation discard the pending command; no done after release.

Verification
REQ-029 SHALL verify: scan lin_matriz 1110,1101,1011,0111 (4 cycles each), key 5, hold 10, bounce 0 -> col_matriz 1101 only while lin_matriz=1101, exactly 10 contact cycles starting the cycle after the first 1101, one done pulse.
REQ-030 SHALL verify: key 0, bounce 2, hold 6, BOUNCE_LEN 3 -> contact pattern 1x3,0x3,1x3,0x3,1x6,0x3,1x3,0x3,1x3, then open, done.
REQ-031 SHALL verify: cmd_valid with key 7 during busy -> ignored, cmd_ready 0; reissued on done cycle -> accepted.
REQ-032 SHALL verify: cmd_abort in HOLD -> contact 0 next cycle, col_matriz 1111, cmd_ready 1, done never pulses.
REQ-033 SHALL verify: rst low in BOUNCE_IN -> col_matriz 1111 before the next clock edge, outputs at reset values, no done after release.
REQ-034 SHALL verify: cmd_hold 0, bounce 0 -> exactly 1 contact cycle, then done.
